// File: rtl/gmii_stream_scoreboard.sv
// Multi-channel GMII loopback checker: captures each channel's Tx frame into a
// per-channel expected FIFO and compares it byte-for-byte (with end-of-frame
// flag) against the frame later received on the matching Rx lane.
// Ports: Clk_125M/Reset (sync, active-high); Tx_en/Txd and Rx_dv/Rxd per-channel
// GMII lanes; clr_cnt clears counters and sticky flags; frame_ok/frame_err are
// one-cycle verdict pulses; ok_cnt/err_cnt saturating counters; ovf/unf sticky
// FIFO overflow/underflow flags.
module gmii_stream_scoreboard #(
  parameter int NUM_CH    = 3,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 2048,
  parameter int STRIP_PRE = 1,
  parameter int CNT_W     = 16
) (
  input  logic                     Clk_125M,
  input  logic                     Reset,
  input  logic [NUM_CH-1:0]        Tx_en,
  input  logic [NUM_CH*DATA_W-1:0] Txd,
  input  logic [NUM_CH-1:0]        Rx_dv,
  input  logic [NUM_CH*DATA_W-1:0] Rxd,
  input  logic                     clr_cnt,
  output logic [NUM_CH-1:0]        frame_ok,
  output logic [NUM_CH-1:0]        frame_err,
  output logic [NUM_CH*CNT_W-1:0]  ok_cnt,
  output logic [NUM_CH*CNT_W-1:0]  err_cnt,
  output logic [NUM_CH-1:0]        ovf,
  output logic [NUM_CH-1:0]        unf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = DATA_W + 1;  // {eof, byte}
  localparam logic [DATA_W-1:0] SFD = DATA_W'(8'hD5);

  typedef enum logic [1:0] {TX_IDLE, TX_PRE, TX_DATA} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_PRE, RX_DATA, RX_DRAIN} rx_state_e;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic              tx_en_w;
    logic [DATA_W-1:0] txd_w;
    logic              rx_dv_w;
    logic [DATA_W-1:0] rxd_w;

    assign tx_en_w = Tx_en[c];
    assign txd_w   = Txd[c*DATA_W +: DATA_W];
    assign rx_dv_w = Rx_dv[c];
    assign rxd_w   = Rxd[c*DATA_W +: DATA_W];

    // ---------------- expected FIFO ----------------
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic          fifo_full, fifo_empty;
    logic          fifo_push, fifo_pop;
    logic [EW-1:0] fifo_rd;

    // ---------------- Tx capture ----------------
    tx_state_e         tx_state_q, tx_state_d;
    logic [DATA_W-1:0] tx_hold_q, tx_hold_d;
    logic              tx_hold_vld_q, tx_hold_vld_d;
    logic              tx_wr;
    logic [EW-1:0]     tx_wr_dat;

    // ---------------- Rx compare ----------------
    rx_state_e         rx_state_q, rx_state_d;
    logic [DATA_W-1:0] rx_hold_q, rx_hold_d;
    logic              rx_hold_vld_q, rx_hold_vld_d;
    logic              rx_mis_q, rx_mis_d;        // mismatch seen in current frame
    logic              rx_exp_done_q, rx_exp_done_d;  // expected frame already ended
    logic              rx_pop;
    logic              cmp_en, cmp_eof;
    logic              verdict, verdict_ok;
    logic              unf_set, ovf_set;

    // ---------------- outputs ----------------
    logic             frame_ok_q, frame_ok_d;
    logic             frame_err_q, frame_err_d;
    logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    assign fifo_full  = (fifo_cnt_q == CW'(DEPTH));
    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_rd    = mem[rd_ptr_q];

    // Tx: each byte waits one cycle in tx_hold so its eof flag is known when
    // it is written (eof=1 only for the byte held when Tx_en falls).
    always_comb begin
      tx_state_d    = tx_state_q;
      tx_hold_d     = tx_hold_q;
      tx_hold_vld_d = tx_hold_vld_q;
      tx_wr         = 1'b0;
      tx_wr_dat     = {1'b0, tx_hold_q};
      unique case (tx_state_q)
        TX_IDLE: begin
          if (tx_en_w) begin
            if (STRIP_PRE == 0) begin
              tx_state_d    = TX_DATA;
              tx_hold_d     = txd_w;
              tx_hold_vld_d = 1'b1;
            end else if (txd_w == SFD) begin
              tx_state_d    = TX_DATA;
              tx_hold_vld_d = 1'b0;
            end else begin
              tx_state_d = TX_PRE;
            end
          end
        end
        TX_PRE: begin
          if (!tx_en_w) begin
            tx_state_d = TX_IDLE;
          end else if (txd_w == SFD) begin
            tx_state_d    = TX_DATA;
            tx_hold_vld_d = 1'b0;
          end
        end
        TX_DATA: begin
          tx_wr = tx_hold_vld_q;
          if (tx_en_w) begin
            tx_hold_d     = txd_w;
            tx_hold_vld_d = 1'b1;
          end else begin
            tx_wr_dat     = {1'b1, tx_hold_q};
            tx_hold_vld_d = 1'b0;
            tx_state_d    = TX_IDLE;
          end
        end
        default: tx_state_d = TX_IDLE;
      endcase
    end

    assign fifo_push = tx_wr && !fifo_full;
    assign ovf_set   = tx_wr && fifo_full;

    // Rx: same staging as Tx, so each Rx entry carries its own eof flag and is
    // checked against exactly one popped expected entry.
    always_comb begin
      rx_state_d    = rx_state_q;
      rx_hold_d     = rx_hold_q;
      rx_hold_vld_d = rx_hold_vld_q;
      rx_mis_d      = rx_mis_q;
      rx_exp_done_d = rx_exp_done_q;
      rx_pop        = 1'b0;
      cmp_en        = 1'b0;
      cmp_eof       = 1'b0;
      verdict       = 1'b0;
      unf_set       = 1'b0;
      unique case (rx_state_q)
        RX_IDLE: begin
          if (rx_dv_w) begin
            rx_mis_d      = 1'b0;
            rx_exp_done_d = 1'b0;
            if (STRIP_PRE == 0) begin
              rx_state_d    = RX_DATA;
              rx_hold_d     = rxd_w;
              rx_hold_vld_d = 1'b1;
            end else if (rxd_w == SFD) begin
              rx_state_d    = RX_DATA;
              rx_hold_vld_d = 1'b0;
            end else begin
              rx_state_d = RX_PRE;
            end
          end
        end
        RX_PRE: begin
          if (!rx_dv_w) begin
            rx_state_d = RX_IDLE;
          end else if (rxd_w == SFD) begin
            rx_state_d    = RX_DATA;
            rx_hold_vld_d = 1'b0;
          end
        end
        RX_DATA: begin
          cmp_en = rx_hold_vld_q;
          if (rx_dv_w) begin
            rx_hold_d     = rxd_w;
            rx_hold_vld_d = 1'b1;
          end else begin
            cmp_eof       = 1'b1;
            rx_hold_vld_d = 1'b0;
            rx_state_d    = RX_IDLE;
            verdict       = 1'b1;
          end
        end
        RX_DRAIN: begin
          // Discard the rest of the expected frame left behind by a short Rx.
          if (fifo_empty) begin
            verdict    = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_pop = 1'b1;
            if (fifo_rd[DATA_W]) begin
              verdict    = 1'b1;
              rx_state_d = RX_IDLE;
            end
          end
        end
        default: rx_state_d = RX_IDLE;
      endcase

      if (cmp_en) begin
        if (rx_exp_done_q) begin
          // Rx long: bytes beyond the expected eof are not popped.
          rx_mis_d = 1'b1;
        end else if (fifo_empty) begin
          unf_set  = 1'b1;
          rx_mis_d = 1'b1;
        end else begin
          rx_pop = 1'b1;
          if (fifo_rd != {cmp_eof, rx_hold_q}) begin
            rx_mis_d = 1'b1;
          end
          if (fifo_rd[DATA_W] && !cmp_eof) begin
            rx_exp_done_d = 1'b1;
          end
          if (!fifo_rd[DATA_W] && cmp_eof) begin
            // Rx short: hold the verdict until the leftovers are drained.
            rx_state_d = RX_DRAIN;
            verdict    = 1'b0;
          end
        end
      end
      verdict_ok = !rx_mis_d;
    end

    assign fifo_pop = rx_pop;

    always_comb begin
      wr_ptr_d   = fifo_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = fifo_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q;
      unique case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
        2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
        default: fifo_cnt_d = fifo_cnt_q;
      endcase
    end

    // Counters and sticky flags; clr_cnt takes priority over same-cycle events.
    always_comb begin
      frame_ok_d  = verdict && verdict_ok;
      frame_err_d = verdict && !verdict_ok;
      ok_cnt_d    = ok_cnt_q;
      err_cnt_d   = err_cnt_q;
      ovf_d       = ovf_q | ovf_set;
      unf_d       = unf_q | unf_set;
      if (clr_cnt) begin
        ok_cnt_d  = '0;
        err_cnt_d = '0;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
      end else begin
        if (frame_ok_d && (ok_cnt_q != '1)) begin
          ok_cnt_d = ok_cnt_q + CNT_W'(1);
        end
        if (frame_err_d && (err_cnt_q != '1)) begin
          err_cnt_d = err_cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge Clk_125M) begin
      if (Reset) begin
        wr_ptr_q      <= '0;
        rd_ptr_q      <= '0;
        fifo_cnt_q    <= '0;
        tx_state_q    <= TX_IDLE;
        tx_hold_q     <= '0;
        tx_hold_vld_q <= 1'b0;
        rx_state_q    <= RX_IDLE;
        rx_hold_q     <= '0;
        rx_hold_vld_q <= 1'b0;
        rx_mis_q      <= 1'b0;
        rx_exp_done_q <= 1'b0;
        frame_ok_q    <= 1'b0;
        frame_err_q   <= 1'b0;
        ok_cnt_q      <= '0;
        err_cnt_q     <= '0;
        ovf_q         <= 1'b0;
        unf_q         <= 1'b0;
      end else begin
        wr_ptr_q      <= wr_ptr_d;
        rd_ptr_q      <= rd_ptr_d;
        fifo_cnt_q    <= fifo_cnt_d;
        tx_state_q    <= tx_state_d;
        tx_hold_q     <= tx_hold_d;
        tx_hold_vld_q <= tx_hold_vld_d;
        rx_state_q    <= rx_state_d;
        rx_hold_q     <= rx_hold_d;
        rx_hold_vld_q <= rx_hold_vld_d;
        rx_mis_q      <= rx_mis_d;
        rx_exp_done_q <= rx_exp_done_d;
        frame_ok_q    <= frame_ok_d;
        frame_err_q   <= frame_err_d;
        ok_cnt_q      <= ok_cnt_d;
        err_cnt_q     <= err_cnt_d;
        ovf_q         <= ovf_d;
        unf_q         <= unf_d;
      end
    end

    // Storage has no reset; the pointers and occupancy define validity.
    always_ff @(posedge Clk_125M) begin
      if (fifo_push) begin
        mem[wr_ptr_q] <= tx_wr_dat;
      end
    end

    assign frame_ok[c]                 = frame_ok_q;
    assign frame_err[c]                = frame_err_q;
    assign ok_cnt[c*CNT_W +: CNT_W]    = ok_cnt_q;
    assign err_cnt[c*CNT_W +: CNT_W]   = err_cnt_q;
    assign ovf[c]                      = ovf_q;
    assign unf[c]                      = unf_q;
  end

endmodule
